wired_commit: RTL and testbench

//  In-order commit stage directly downstream of the ROB. Owns the ROB head pointer and drives the
//  two ROB C-level read addresses. Retires up to 2 completed entries/cycle: writes ARF, releases

---
 rtl/wired_commit.sv | 157 +++++++++++++++
 tb/tb_wired_commit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/wired_commit.sv
// In-order commit stage: owns the ROB head, retires up to two completed entries
// per cycle, and on exception/mispredict redirects the front end and drains the ROB.
module wired_commit #(
   parameter int unsigned ROB_LEN = 6,
   parameter int unsigned XLEN    = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [1:0]              p_dispatch_i,
   output logic [2*ROB_LEN-1:0]    c_rrrid_o,
   input  logic [1:0]              c_valid_i,
   input  logic [1:0]              c_excp_i,
   input  logic [1:0]              c_jump_i,
   input  logic [2*XLEN-1:0]       c_target_i,
   input  logic [2*XLEN-1:0]       c_pc_i,
   input  logic [1:0]              c_store_i,
   input  logic [9:0]              c_wreg_i,
   input  logic [2*XLEN-1:0]       c_wdata_i,
   output logic [1:0]              c_retire_o,
   output logic [1:0]              arf_we_o,
   output logic [9:0]              arf_waddr_o,
   output logic [2*XLEN-1:0]       arf_wdata_o,
   output logic                    sb_commit_o,
   input  logic                    sb_ready_i,
   input  logic [XLEN-1:0]         excp_vec_i,
   output logic                    flush_o,
   output logic                    redirect_o,
   output logic [XLEN-1:0]         redirect_pc_o,
   output logic [XLEN-1:0]         epc_o
);

   localparam int unsigned OCC_W     = ROB_LEN + 1;
   localparam int unsigned ROB_DEPTH = 1 << ROB_LEN;

   typedef enum logic {ST_RUN, ST_FLUSH} state_t;

   state_t               state_q, state_d;
   logic [ROB_LEN-1:0]   head_q, head_d;
   logic [OCC_W-1:0]     occ_q, occ_d;
   logic                 redirect_q, redirect_d;
   logic [XLEN-1:0]      redirect_pc_q, redirect_pc_d;
   logic [XLEN-1:0]      epc_q, epc_d;

   logic                 run_c, occ_ge1_c, occ_ge2_c;
   logic                 brk0_ev_c, brk1_ev_c;
   logic                 ret0_c, ret1_c, brk0_c, brk1_c;
   logic [4:0]           wreg0_c, wreg1_c;

   function automatic logic [1:0] pop2(input logic [1:0] v);
      return {1'b0, v[1]} + {1'b0, v[0]};
   endfunction

   assign wreg0_c   = c_wreg_i[4:0];
   assign wreg1_c   = c_wreg_i[9:5];
   assign occ_ge1_c = (occ_q >= OCC_W'(1));
   assign occ_ge2_c = (occ_q >= OCC_W'(2));
   assign run_c     = rst_n && (state_q == ST_RUN);
   assign brk0_ev_c = c_excp_i[0] | c_jump_i[0];
   assign brk1_ev_c = c_excp_i[1] | c_jump_i[1];

   // Same-cycle retire decision for the two head slots in RUN.
   assign ret0_c = run_c & c_valid_i[0] & occ_ge1_c & (~c_store_i[0] | sb_ready_i);
   assign brk0_c = ret0_c & brk0_ev_c;
   assign ret1_c = ret0_c & ~brk0_ev_c & c_valid_i[1] & occ_ge2_c
                 & ~(c_store_i[0] & c_store_i[1]) & (~c_store_i[1] | sb_ready_i);
   assign brk1_c = ret1_c & brk1_ev_c;

   // ROB read addresses follow the head directly.
   assign c_rrrid_o = {head_q + ROB_LEN'(1), head_q};

   assign arf_waddr_o   = c_wreg_i;
   assign arf_wdata_o   = c_wdata_i;
   assign flush_o       = (state_q == ST_FLUSH);
   assign redirect_o    = redirect_q;
   assign redirect_pc_o = redirect_pc_q;
   assign epc_o         = epc_q;

   // Next-state, retire/commit strobes and redirect capture.
   always_comb begin
      state_d       = state_q;
      c_retire_o    = 2'b00;
      arf_we_o      = 2'b00;
      sb_commit_o   = 1'b0;
      redirect_d    = 1'b0;
      redirect_pc_d = '0;
      epc_d         = '0;
      if (rst_n) begin
         case (state_q)
            ST_RUN: begin
               c_retire_o  = {ret1_c, ret0_c};
               arf_we_o[0] = ret0_c & (wreg0_c != 5'd0) & ~c_excp_i[0];
               arf_we_o[1] = ret1_c & (wreg1_c != 5'd0) & ~c_excp_i[1];
               sb_commit_o = (ret0_c & c_store_i[0] & ~c_excp_i[0])
                           | (ret1_c & c_store_i[1] & ~c_excp_i[1]);
               if (brk0_c) begin
                  state_d    = ST_FLUSH;
                  redirect_d = 1'b1;
                  if (c_excp_i[0]) begin
                     redirect_pc_d = excp_vec_i;
                     epc_d         = c_pc_i[XLEN-1:0];
                  end else begin
                     redirect_pc_d = c_target_i[XLEN-1:0];
                  end
               end else if (brk1_c) begin
                  state_d    = ST_FLUSH;
                  redirect_d = 1'b1;
                  if (c_excp_i[1]) begin
                     redirect_pc_d = excp_vec_i;
                     epc_d         = c_pc_i[2*XLEN-1:XLEN];
                  end else begin
                     redirect_pc_d = c_target_i[2*XLEN-1:XLEN];
                  end
               end
            end
            ST_FLUSH: begin
               // Drain regardless of completion; leave once the ROB is empty.
               c_retire_o = {occ_ge2_c, occ_ge1_c};
               if (!occ_ge2_c) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   assign occ_d  = occ_q + OCC_W'(pop2(p_dispatch_i)) - OCC_W'(pop2(c_retire_o));
   assign head_d = head_q + ROB_LEN'(pop2(c_retire_o));

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_RUN;
         head_q        <= '0;
         occ_q         <= '0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         epc_q         <= '0;
      end else begin
         state_q       <= state_d;
         head_q        <= head_d;
         occ_q         <= occ_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         epc_q         <= epc_d;
      end
   end

   // Protocol checks: no dispatch during flush, occupancy bounded by ROB depth.
   always @(posedge clk) begin
      if (rst_n) begin
         assert (!(flush_o && (p_dispatch_i != 2'b00)))
            else $error("dispatch while flush active");
         assert (occ_q <= OCC_W'(ROB_DEPTH))
            else $error("ROB occupancy overflow");
      end
   end

endmodule

// File: tb/tb_wired_commit.sv
// Directed bench for wired_commit: retire width, store gating, flush/drain, wrap, reset.
module tb_wired_commit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  p_dispatch_i;
   logic [11:0] c_rrrid_o;
   logic [1:0]  c_valid_i, c_excp_i, c_jump_i, c_store_i;
   logic [63:0] c_target_i, c_pc_i, c_wdata_i;
   logic [9:0]  c_wreg_i;
   logic [1:0]  c_retire_o, arf_we_o;
   logic [9:0]  arf_waddr_o;
   logic [63:0] arf_wdata_o;
   logic        sb_commit_o, sb_ready_i, flush_o, redirect_o;
   logic [31:0] excp_vec_i, redirect_pc_o, epc_o;

   int checks = 0;
   int errors = 0;

   wired_commit #(.ROB_LEN(6), .XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .p_dispatch_i(p_dispatch_i), .c_rrrid_o(c_rrrid_o),
      .c_valid_i(c_valid_i), .c_excp_i(c_excp_i), .c_jump_i(c_jump_i),
      .c_target_i(c_target_i), .c_pc_i(c_pc_i), .c_store_i(c_store_i),
      .c_wreg_i(c_wreg_i), .c_wdata_i(c_wdata_i), .c_retire_o(c_retire_o),
      .arf_we_o(arf_we_o), .arf_waddr_o(arf_waddr_o), .arf_wdata_o(arf_wdata_o),
      .sb_commit_o(sb_commit_o), .sb_ready_i(sb_ready_i), .excp_vec_i(excp_vec_i),
      .flush_o(flush_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
      .epc_o(epc_o)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] rid(input int h);
      logic [5:0] a, b;
      a = 6'(h);
      b = 6'(h + 1);
      return {b, a};
   endfunction

   task automatic clear_inputs();
      p_dispatch_i = 2'b00; c_valid_i = 2'b00; c_excp_i = 2'b00; c_jump_i = 2'b00;
      c_store_i = 2'b00; c_target_i = '0; c_pc_i = '0; c_wreg_i = '0; c_wdata_i = '0;
      sb_ready_i = 1'b0; excp_vec_i = '0;
   endtask

   // Inputs are driven at negedge; settled outputs are sampled 1 time unit later.
   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   task automatic dispatch(input logic [1:0] d);
      p_dispatch_i = d;
      next_cycle();
      p_dispatch_i = 2'b00;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_inputs();
      next_cycle();
      next_cycle();
      checks++; if (c_rrrid_o !== 12'h040) begin errors++; $display("FAIL reset_rrrid got %h want 040", c_rrrid_o); end
      checks++; if ({c_retire_o, arf_we_o, sb_commit_o, flush_o, redirect_o} !== 7'b0) begin errors++; $display("FAIL reset_ctl got %b want 0", {c_retire_o, arf_we_o, sb_commit_o, flush_o, redirect_o}); end
      checks++; if ({redirect_pc_o, epc_o} !== 64'h0) begin errors++; $display("FAIL reset_pc got %h want 0", {redirect_pc_o, epc_o}); end
      rst_n = 1'b1;
      next_cycle();
      checks++; if (dut.occ_q !== 7'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", dut.occ_q); end
   endtask

   task automatic test_alu();
      dispatch(2'b11);
      dispatch(2'b11);
      checks++; if (dut.occ_q !== 7'd4) begin errors++; $display("FAIL alu_occ4 got %0d want 4", dut.occ_q); end
      c_valid_i = 2'b11; c_wreg_i = {5'd2, 5'd1}; c_wdata_i = 64'h0000_2222_0000_1111;
      #1;
      checks++; if ({c_retire_o, arf_we_o} !== 4'b1111) begin errors++; $display("FAIL alu_c1 got %b want 1111", {c_retire_o, arf_we_o}); end
      checks++; if (arf_waddr_o !== 10'b00010_00001) begin errors++; $display("FAIL alu_waddr got %h want 041", arf_waddr_o); end
      next_cycle();
      checks++; if (c_rrrid_o !== rid(2)) begin errors++; $display("FAIL alu_rid2 got %h want %h", c_rrrid_o, rid(2)); end
      checks++; if ({c_retire_o, arf_we_o} !== 4'b1111) begin errors++; $display("FAIL alu_c2 got %b want 1111", {c_retire_o, arf_we_o}); end
      next_cycle();
      checks++; if (c_rrrid_o !== rid(4)) begin errors++; $display("FAIL alu_rid4 got %h want %h", c_rrrid_o, rid(4)); end
      checks++; if ({c_retire_o, arf_we_o} !== 4'b0000) begin errors++; $display("FAIL alu_empty got %b want 0000", {c_retire_o, arf_we_o}); end
      checks++; if (dut.occ_q !== 7'd0) begin errors++; $display("FAIL alu_occ0 got %0d want 0", dut.occ_q); end
      clear_inputs();
   endtask

   task automatic test_two_stores();
      dispatch(2'b11);
      c_valid_i = 2'b11; c_store_i = 2'b11; sb_ready_i = 1'b1;
      #1;
      checks++; if ({c_retire_o, sb_commit_o, arf_we_o} !== 5'b01100) begin errors++; $display("FAIL st2_a got %b want 01100", {c_retire_o, sb_commit_o, arf_we_o}); end
      next_cycle();
      checks++; if ({c_retire_o, sb_commit_o} !== 3'b011) begin errors++; $display("FAIL st2_b got %b want 011", {c_retire_o, sb_commit_o}); end
      next_cycle();
      checks++; if (c_rrrid_o !== rid(6)) begin errors++; $display("FAIL st2_rid got %h want %h", c_rrrid_o, rid(6)); end
      clear_inputs();
   endtask

   task automatic test_store_stall();
      dispatch(2'b01);
      c_valid_i = 2'b01; c_store_i = 2'b01; sb_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if ({c_retire_o, sb_commit_o} !== 3'b000) begin errors++; $display("FAIL stall_%0d got %b want 000", i, {c_retire_o, sb_commit_o}); end
         next_cycle();
      end
      sb_ready_i = 1'b1;
      #1;
      checks++; if ({c_retire_o, sb_commit_o} !== 3'b011) begin errors++; $display("FAIL stall_go got %b want 011", {c_retire_o, sb_commit_o}); end
      next_cycle();
      checks++; if (c_rrrid_o !== rid(7)) begin errors++; $display("FAIL stall_rid got %h want %h", c_rrrid_o, rid(7)); end
      clear_inputs();
   endtask

   task automatic test_jump_flush();
      logic [1:0] exp_ret [3];
      exp_ret[0] = 2'b11; exp_ret[1] = 2'b11; exp_ret[2] = 2'b01;
      dispatch(2'b11); dispatch(2'b11); dispatch(2'b11); dispatch(2'b01);
      c_valid_i = 2'b11; c_jump_i = 2'b10; c_target_i = {32'h1c000100, 32'h0};
      c_wreg_i = {5'd4, 5'd3};
      #1;
      checks++; if ({c_retire_o, arf_we_o, redirect_o} !== 5'b11110) begin errors++; $display("FAIL jmp_trig got %b want 11110", {c_retire_o, arf_we_o, redirect_o}); end
      next_cycle();
      c_valid_i = 2'b00; c_jump_i = 2'b00;
      #1;
      checks++; if ({redirect_o, redirect_pc_o} !== {1'b1, 32'h1c000100}) begin errors++; $display("FAIL jmp_redir got %b/%h want 1/1c000100", redirect_o, redirect_pc_o); end
      for (int i = 0; i < 3; i++) begin
         checks++; if ({flush_o, c_retire_o, arf_we_o, sb_commit_o} !== {1'b1, exp_ret[i], 3'b000}) begin errors++; $display("FAIL jmp_drain_%0d got %b want %b", i, {flush_o, c_retire_o, arf_we_o, sb_commit_o}, {1'b1, exp_ret[i], 3'b000}); end
         next_cycle();
         if (i == 0) begin
            checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL jmp_pulse got %b want 0", redirect_o); end
         end
      end
      checks++; if ({flush_o, c_retire_o} !== 3'b000) begin errors++; $display("FAIL jmp_end got %b want 000", {flush_o, c_retire_o}); end
      checks++; if (c_rrrid_o !== rid(14)) begin errors++; $display("FAIL jmp_rid got %h want %h", c_rrrid_o, rid(14)); end
      clear_inputs();
   endtask

   task automatic test_excp();
      dispatch(2'b11);
      c_valid_i = 2'b11; c_excp_i = 2'b01; c_pc_i = {32'h84, 32'h80};
      excp_vec_i = 32'h1c008000; c_wreg_i = {5'd6, 5'd5};
      #1;
      checks++; if ({c_retire_o, arf_we_o, sb_commit_o} !== 5'b01000) begin errors++; $display("FAIL exc_trig got %b want 01000", {c_retire_o, arf_we_o, sb_commit_o}); end
      next_cycle();
      clear_inputs();
      #1;
      checks++; if ({redirect_o, redirect_pc_o, epc_o} !== {1'b1, 32'h1c008000, 32'h80}) begin errors++; $display("FAIL exc_redir got %b/%h/%h want 1/1c008000/80", redirect_o, redirect_pc_o, epc_o); end
      checks++; if ({flush_o, c_retire_o, arf_we_o} !== 5'b10100) begin errors++; $display("FAIL exc_drain got %b want 10100", {flush_o, c_retire_o, arf_we_o}); end
      next_cycle();
      checks++; if ({flush_o, redirect_o} !== 2'b00) begin errors++; $display("FAIL exc_end got %b want 00", {flush_o, redirect_o}); end
      checks++; if (c_rrrid_o !== rid(16)) begin errors++; $display("FAIL exc_rid got %h want %h", c_rrrid_o, rid(16)); end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 23; i++) begin
         dispatch(2'b11);
         c_valid_i = 2'b11;
         next_cycle();
         c_valid_i = 2'b00;
      end
      checks++; if (c_rrrid_o !== rid(62)) begin errors++; $display("FAIL wrap_rid62 got %h want %h", c_rrrid_o, rid(62)); end
      dispatch(2'b11); dispatch(2'b11);
      c_valid_i = 2'b11;
      #1;
      checks++; if ({c_rrrid_o, c_retire_o} !== {6'd63, 6'd62, 2'b11}) begin errors++; $display("FAIL wrap_a got %h/%b want fbe/11", c_rrrid_o, c_retire_o); end
      next_cycle();
      checks++; if ({c_rrrid_o, c_retire_o} !== {6'd1, 6'd0, 2'b11}) begin errors++; $display("FAIL wrap_b got %h/%b want 040/11", c_rrrid_o, c_retire_o); end
      next_cycle();
      checks++; if ({c_rrrid_o, c_retire_o} !== {6'd3, 6'd2, 2'b00}) begin errors++; $display("FAIL wrap_c got %h/%b want 0c2/00", c_rrrid_o, c_retire_o); end
      clear_inputs();
   endtask

   task automatic test_reset_mid_flush();
      dispatch(2'b11); dispatch(2'b01);
      c_valid_i = 2'b01; c_jump_i = 2'b01; c_target_i = {32'h0, 32'h00001234};
      next_cycle();
      clear_inputs();
      rst_n = 1'b0;
      #1;
      checks++; if (c_retire_o !== 2'b00) begin errors++; $display("FAIL rstf_ret got %b want 00", c_retire_o); end
      next_cycle();
      checks++; if ({flush_o, redirect_o, redirect_pc_o} !== 34'h0) begin errors++; $display("FAIL rstf_ctl got %b/%b/%h want 0/0/0", flush_o, redirect_o, redirect_pc_o); end
      checks++; if ({c_rrrid_o, dut.occ_q} !== {12'h040, 7'd0}) begin errors++; $display("FAIL rstf_state got %h/%0d want 040/0", c_rrrid_o, dut.occ_q); end
      rst_n = 1'b1;
      next_cycle();
      checks++; if ({flush_o, redirect_o} !== 2'b00) begin errors++; $display("FAIL rstf_after got %b want 00", {flush_o, redirect_o}); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_alu();
      test_two_stores();
      test_store_stall();
      test_jump_flush();
      test_excp();
      test_wrap();
      test_reset_mid_flush();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
